branch_predictor_nway: RTL and testbench

BRANCH_PREDICTOR_NWAY -- requirements
Module: branch_predictor_nway

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_line.sv | 63 ++++++
 rtl/branch_predictor_nway.sv | 93 +++++++++
 tb/tb_branch_predictor_nway.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the n-way branch predictor.
//   bp_ctr_e  - 2-bit saturating counter encodings
//   bp_cmd_t  - resolved per-line command (allocate / outcome update)
//   bp_index  - line index of an address (word-aligned PCs)
//   bp_tag    - tag of an address (everything above the index)
package bp_pkg;

   localparam int ADDR_W = 32;
   localparam int CTR_W  = 2;

   typedef enum logic [CTR_W-1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_e;

   // One command per line per cycle; we wins over us.
   typedef struct packed {
      logic              we;
      logic              us;
      logic              t;
      logic [ADDR_W-1:0] wd;
   } bp_cmd_t;

   // Callers size-cast the result down to IDXW bits.
   function automatic logic [ADDR_W-1:0] bp_index(input logic [ADDR_W-1:0] a, input int idxw);
      return (a >> 2) & ((ADDR_W'(1) << idxw) - ADDR_W'(1));
   endfunction

   // Callers size-cast the result down to TAGW bits.
   function automatic logic [ADDR_W-1:0] bp_tag(input logic [ADDR_W-1:0] a, input int idxw);
      return a >> (idxw + 2);
   endfunction

endpackage

// File: rtl/bp_line.sv
// bp_line: one BTB line with local history and a pattern table of
// 2-bit saturating counters.
//   clk, reset - clock, async active-low reset
//   cmd        - resolved command for this line (allocate or outcome update)
//   wtag       - tag stored on allocate
//   valid, tag, target - line state for lookup
//   pred       - MSB of the counter selected by the current history
module bp_line
   import bp_pkg::*;
#(
   parameter int TAGW = 26,
   parameter int HIST = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  bp_cmd_t         cmd,
   input  logic [TAGW-1:0] wtag,
   output logic            valid,
   output logic [TAGW-1:0] tag,
   output logic [31:0]     target,
   output logic            pred
);

   localparam int NCTR = 2**HIST;

   logic [HIST-1:0]             hist_q;
   logic [NCTR-1:0][CTR_W-1:0]  ctr_q;
   logic [CTR_W-1:0]            cur, nxt;
   logic [HIST-1:0]             hist_nx;

   always_comb begin
      cur = ctr_q[hist_q];
      nxt = cur;
      if (cmd.t) begin
         if (cur != ST) nxt = cur + 2'd1;
      end else begin
         if (cur != SNT) nxt = cur - 2'd1;
      end
      hist_nx = {hist_q[HIST-2:0], cmd.t};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid  <= 1'b0;
         tag    <= '0;
         target <= '0;
         hist_q <= '0;
         for (int i = 0; i < NCTR; i++) ctr_q[i] <= WNT;
      end else if (cmd.we) begin
         valid  <= 1'b1;
         tag    <= wtag;
         target <= cmd.wd;
         hist_q <= '0;
         for (int i = 0; i < NCTR; i++) ctr_q[i] <= WNT;
      end else if (cmd.us) begin
         ctr_q[hist_q] <= nxt;
         hist_q        <= hist_nx;
      end
   end

   assign pred = ctr_q[hist_q][1];

endmodule

// File: rtl/branch_predictor_nway.sv
// branch_predictor_nway: direct-mapped BTB with per-line local-history
// direction prediction and NPORT independent read/update port pairs.
//   clk, reset      - clock, async active-low reset
//   RA / RD, P, HIT - per-port fetch PC in; target, taken, hit out (comb)
//   WE, WA, WD      - per-port allocate strobe, branch PC, target
//   US, T           - per-port outcome update strobe and outcome (uses WA)
// Lookup is purely combinational on registered line state, so updates
// become visible the cycle after their edge.
module branch_predictor_nway
   import bp_pkg::*;
#(
   parameter int NPORT   = 2,
   parameter int ENTRIES = 16,
   parameter int HIST    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NPORT*32-1:0] RA,
   output logic [NPORT*32-1:0] RD,
   output logic [NPORT-1:0]    P,
   output logic [NPORT-1:0]    HIT,
   input  logic [NPORT-1:0]    WE,
   input  logic [NPORT*32-1:0] WA,
   input  logic [NPORT*32-1:0] WD,
   input  logic [NPORT-1:0]    US,
   input  logic [NPORT-1:0]    T
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = ADDR_W - IDXW - 2;

   logic [ENTRIES-1:0]            l_valid, l_pred;
   logic [ENTRIES-1:0][TAGW-1:0]  l_tag;
   logic [ENTRIES-1:0][31:0]      l_target;

   logic [NPORT-1:0][IDXW-1:0]    r_idx, w_idx;
   logic [NPORT-1:0][TAGW-1:0]    r_tag, w_tag;

   // Address decode and lookup per port
   for (genvar k = 0; k < NPORT; k++) begin : g_port
      assign r_idx[k] = IDXW'(bp_index(RA[k*32 +: 32], IDXW));
      assign r_tag[k] = TAGW'(bp_tag(RA[k*32 +: 32], IDXW));
      assign w_idx[k] = IDXW'(bp_index(WA[k*32 +: 32], IDXW));
      assign w_tag[k] = TAGW'(bp_tag(WA[k*32 +: 32], IDXW));

      assign HIT[k]          = l_valid[r_idx[k]] && (l_tag[r_idx[k]] == r_tag[k]);
      assign RD[k*32 +: 32]  = HIT[k] ? l_target[r_idx[k]] : 32'h0;
      assign P[k]            = HIT[k] && l_pred[r_idx[k]];
   end

   // Per-line arbitration: ascending scan so the highest-numbered port
   // wins within each operation; an allocate suppresses any update.
   for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
      localparam logic [IDXW-1:0] EIDX = IDXW'(e);
      bp_cmd_t         cmd;
      logic [TAGW-1:0] wtag;

      always_comb begin
         cmd  = '0;
         wtag = '0;
         for (int k = 0; k < NPORT; k++) begin
            if (WE[k] && w_idx[k] == EIDX) begin
               cmd.we = 1'b1;
               cmd.wd = WD[k*32 +: 32];
               wtag   = w_tag[k];
            end
         end
         // Updates only apply to a hit against the pre-edge line state.
         for (int k = 0; k < NPORT; k++) begin
            if (US[k] && w_idx[k] == EIDX && l_valid[e] && l_tag[e] == w_tag[k]) begin
               cmd.us = 1'b1;
               cmd.t  = T[k];
            end
         end
         if (cmd.we) begin
            cmd.us = 1'b0;
            cmd.t  = 1'b0;
         end
      end

      bp_line #(.TAGW(TAGW), .HIST(HIST)) u_line (
         .clk    (clk),
         .reset  (reset),
         .cmd    (cmd),
         .wtag   (wtag),
         .valid  (l_valid[e]),
         .tag    (l_tag[e]),
         .target (l_target[e]),
         .pred   (l_pred[e])
      );
   end

endmodule

// File: tb/tb_branch_predictor_nway.sv
// Directed bench for branch_predictor_nway (NPORT=2, ENTRIES=16, HIST=4).
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_branch_predictor_nway;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] RA = '0, WA = '0, WD = '0;
   logic [63:0] RD;
   logic [1:0]  P, HIT;
   logic [1:0]  WE = '0, US = '0, T = '0;

   int n_chk = 0;
   int n_err = 0;

   branch_predictor_nway #(.NPORT(2), .ENTRIES(16), .HIST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .RA    (RA),
      .RD    (RD),
      .P     (P),
      .HIT   (HIT),
      .WE    (WE),
      .WA    (WA),
      .WD    (WD),
      .US    (US),
      .T     (T)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state, before any edge
      RA[31:0] = 32'h2222;
      #1;
      chk("rst_hit", 32'(HIT[0]), 0);
      chk("rst_p",   32'(P[0]),   0);
      chk("rst_rd",  RD[31:0],    0);
      tick; tick;
      reset = 1'b1;
      tick;

      // Allocate 0x2222; same-cycle read still sees the empty line
      WE = 2'b01; WA[31:0] = 32'h2222; WD[31:0] = 32'h69696969;
      #1;
      chk("nobypass_hit", 32'(HIT[0]), 0);
      tick;
      WE = '0;
      #1;
      chk("alloc_hit", 32'(HIT[0]), 1);
      chk("alloc_rd",  RD[31:0],    32'h69696969);
      chk("alloc_p",   32'(P[0]),   0);

      // Pattern learning: T = 1,0,1,0,... ; prediction before each edge
      US = 2'b01;
      for (int c = 0; c < 20; c++) begin
         T[0] = (c % 2 == 0);
         #1;
         if (c >= 8) chk($sformatf("pat%0d", c), 32'(P[0]), 32'(T[0]));
         tick;
      end
      US = '0;
      #1;
      chk("pat_end_p", 32'(P[0]), 1);

      // Saturation on line 0 (0x3000) through port 1
      WE = 2'b10; WA[63:32] = 32'h3000; WD[63:32] = 32'h33330000; RA[63:32] = 32'h3000;
      tick;
      WE = '0;
      US = 2'b10; T[1] = 1'b1;
      for (int i = 0; i < 4; i++) tick;   // history -> 1111
      chk("sat_pre_p", 32'(P[1]), 0);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk($sformatf("sat_t%0d", i), 32'(P[1]), 1);
      end
      T[1] = 1'b0;
      #1;
      chk("sat_nt_pre", 32'(P[1]), 1);
      tick;                               // ctr[15] 11->10, history 1110
      chk("sat_nt_p", 32'(P[1]), 0);
      T[1] = 1'b1;
      for (int i = 0; i < 4; i++) tick;   // back to history 1111
      chk("sat_dec_p", 32'(P[1]), 1);
      T[1] = 1'b0;
      tick;                               // ctr[15] 10->01
      T[1] = 1'b1;
      for (int i = 0; i < 4; i++) tick;
      chk("sat_dec2_p", 32'(P[1]), 0);
      US = '0;

      // Conflict: WE[1] and US[0] on the same line in one cycle
      WE = 2'b01; WA[31:0] = 32'h6969; WD[31:0] = 32'h11111111;
      tick;
      WE = '0;
      US = 2'b01; T[0] = 1'b1;
      tick;
      WE = 2'b10; WA[63:32] = 32'h6969; WD[63:32] = 32'h42042042;
      US = 2'b01; T[0] = 1'b1;
      tick;
      WE = '0; US = '0;
      RA[31:0] = 32'h6969;
      #1;
      chk("cf_hit", 32'(HIT[0]), 1);
      chk("cf_rd",  RD[31:0],    32'h42042042);
      chk("cf_p",   32'(P[0]),   0);
      US = 2'b01; T[0] = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      US = '0;
      #1;
      chk("cf_hist_p", 32'(P[0]), 0);

      // WE and US on different lines in the same cycle both apply
      RA[31:0] = 32'h2222; WA[31:0] = 32'h2222;
      #1;
      chk("par_pre_p", 32'(P[0]), 1);
      US = 2'b01; T[0] = 1'b0;
      WE = 2'b10; WA[63:32] = 32'h4444; WD[63:32] = 32'h44440000;
      tick;
      US = '0; WE = '0;
      RA[63:32] = 32'h4444;
      #1;
      chk("par_hit1", 32'(HIT[1]), 1);
      chk("par_rd1",  RD[63:32],   32'h44440000);
      chk("par_p0",   32'(P[0]),   0);

      // Both ports allocate the same line: port 1 wins
      WE = 2'b11; WA = {32'h5550, 32'h5550}; WD = {32'hBBBB0000, 32'hAAAA0000};
      tick;
      WE = '0;
      RA[31:0] = 32'h5550;
      #1;
      chk("multi_rd", RD[31:0], 32'hBBBB0000);

      // Mid-run reset: outputs clear immediately, WE during reset dropped
      RA[31:0] = 32'h2222;
      #1;
      chk("mid_pre_hit", 32'(HIT[0]), 1);
      WE = 2'b01; WA[31:0] = 32'h7770; WD[31:0] = 32'h77770000;
      reset = 1'b0;
      #1;
      chk("mid_hit",  32'(HIT),   0);
      chk("mid_p",    32'(P),     0);
      chk("mid_rd0",  RD[31:0],   0);
      chk("mid_rd1",  RD[63:32],  0);
      tick;
      reset = 1'b1;
      WE = '0;
      tick;
      chk("mid_old_hit", 32'(HIT[0]), 0);
      RA[31:0] = 32'h7770;
      #1;
      chk("mid_we_drop", 32'(HIT[0]), 0);

      // Aliasing: 0x2262 evicts 0x2222 from line 8
      WE = 2'b01; WA[31:0] = 32'h2222; WD[31:0] = 32'h22220000;
      tick;
      WA[31:0] = 32'h2262; WD[31:0] = 32'h26260000;
      tick;
      WE = '0;
      RA = {32'h2262, 32'h2222};
      #1;
      chk("al_hit0", 32'(HIT[0]), 0);
      chk("al_rd0",  RD[31:0],    0);
      chk("al_hit1", 32'(HIT[1]), 1);
      chk("al_rd1",  RD[63:32],   32'h26260000);
      // Train 0x2262 to history 0000 with ctr[0] = 10
      US = 2'b10; WA[63:32] = 32'h2262;
      T[1] = 1'b1; tick;
      T[1] = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      US = '0;
      #1;
      chk("al_pre_p", 32'(P[1]), 1);
      US = 2'b01; WA[31:0] = 32'h2222; T[0] = 1'b0;
      tick;
      US = '0;
      #1;
      chk("al_ign_p",   32'(P[1]),   1);
      chk("al_ign_hit", 32'(HIT[0]), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
